// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// pipe_hazard_ctrl: register-hazard stall, bubble and branch-flush control for the 5-stage pipeline.
// Define PIPE_FWD_EN to enable EXEC operand forwarding with a load-use-only stall rule.
module pipe_hazard_ctrl #(
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              dec_valid,
   input  logic [REG_AW-1:0] dec_rs_a,
   input  logic [REG_AW-1:0] dec_rs_b,
   input  logic              dec_use_a,
   input  logic              dec_use_b,
   input  logic [REG_AW-1:0] dec_rd,
   input  logic              dec_wr_en,
   input  logic              dec_is_load,
   input  logic              ex_branch_taken,
   output logic              pc_en,
   output logic              fd_en,
   output logic              fd_flush,
   output logic              de_bubble,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [2:0]        stage_valid,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              wr_en;
      logic              is_load;
      logic [REG_AW-1:0] rs_a;
      logic [REG_AW-1:0] rs_b;
      logic              use_a;
      logic              use_b;
   } trk_t;

   localparam logic [REG_AW-1:0] PC_REG  = REG_AW'(15);
   localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   trk_t             r_ex;
   trk_t             r_mem;
   trk_t             r_wb;
   trk_t             w_ex_nxt;
   logic             w_hazard;
   logic             w_flush;
   logic             w_stall;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_unused;

   function automatic logic src_match(input logic use_src, input logic [REG_AW-1:0] src,
                                      input trk_t stg);
      return use_src && stg.valid && stg.wr_en && (stg.rd == src) && (src != PC_REG);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      logic [CNT_W-1:0] nxt;
      if (cnt == CNT_MAX) begin
         nxt = cnt;
      end else begin
         nxt = cnt + CNT_ONE;
      end
      return nxt;
   endfunction

`ifdef PIPE_FWD_EN
   // MEMW is younger than WRBK so it wins; a load in MEMW is never a forwarding source
   function automatic logic [1:0] fwd_pick(input logic use_src, input logic [REG_AW-1:0] src,
                                           input trk_t mem, input trk_t wb);
      logic [1:0] sel;
      if (src_match(use_src, src, mem) && !mem.is_load) begin
         sel = 2'd1;
      end else if (src_match(use_src, src, wb)) begin
         sel = 2'd2;
      end else begin
         sel = 2'd0;
      end
      return sel;
   endfunction
`endif

   // Hazard detection for the DECD instruction against the in-flight writers
   always_comb begin
      w_hazard = 1'b0;
`ifdef PIPE_FWD_EN
      w_hazard = r_ex.is_load &&
                 (src_match(dec_use_a, dec_rs_a, r_ex) || src_match(dec_use_b, dec_rs_b, r_ex));
`else
      w_hazard = src_match(dec_use_a, dec_rs_a, r_ex)  || src_match(dec_use_b, dec_rs_b, r_ex)  ||
                 src_match(dec_use_a, dec_rs_a, r_mem) || src_match(dec_use_b, dec_rs_b, r_mem) ||
                 src_match(dec_use_a, dec_rs_a, r_wb)  || src_match(dec_use_b, dec_rs_b, r_wb);
`endif
   end

   // Stage enable decode: a taken branch in EXEC overrides any stall
   always_comb begin
      w_flush = ex_branch_taken && r_ex.valid;
      w_stall = 1'b0;
      if (w_flush) begin
         pc_en     = 1'b1;
         fd_en     = 1'b1;
         fd_flush  = 1'b1;
         de_bubble = 1'b1;
      end else if (dec_valid && w_hazard) begin
         w_stall   = 1'b1;
         pc_en     = 1'b0;
         fd_en     = 1'b0;
         fd_flush  = 1'b0;
         de_bubble = 1'b1;
      end else begin
         pc_en     = 1'b1;
         fd_en     = 1'b1;
         fd_flush  = 1'b0;
         de_bubble = 1'b0;
      end
   end

   // Entry entering EXEC on the next edge: the DECD instruction or a zeroed bubble
   always_comb begin
      w_ex_nxt = '0;
      if (dec_valid && !de_bubble) begin
         w_ex_nxt.valid   = 1'b1;
         w_ex_nxt.rd      = dec_rd;
         w_ex_nxt.wr_en   = dec_wr_en;
         w_ex_nxt.is_load = dec_is_load;
         w_ex_nxt.rs_a    = dec_rs_a;
         w_ex_nxt.rs_b    = dec_rs_b;
         w_ex_nxt.use_a   = dec_use_a;
         w_ex_nxt.use_b   = dec_use_b;
      end else begin
         w_ex_nxt = '0;
      end
   end

`ifdef PIPE_FWD_EN
   // Operand forwarding selects for the instruction currently in EXEC
   always_comb begin
      fwd_a_sel = fwd_pick(r_ex.use_a, r_ex.rs_a, r_mem, r_wb);
      fwd_b_sel = fwd_pick(r_ex.use_b, r_ex.rs_b, r_mem, r_wb);
   end
`else
   assign fwd_a_sel = 2'd0;
   assign fwd_b_sel = 2'd0;
`endif

   // Tracking shift register EXEC -> MEMW -> WRBK
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         r_ex  <= w_ex_nxt;
      end
   end

   // Saturating stall and flush event counters
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_flush) begin
            r_flush_cnt <= sat_inc(r_flush_cnt);
         end else begin
            r_flush_cnt <= r_flush_cnt;
         end
         if (w_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
      end
   end

   assign stage_valid = {r_wb.valid, r_mem.valid, r_ex.valid};
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;

   // Entry fields kept for visibility but not consumed in every build
   assign w_unused = ^{r_ex, r_mem, r_wb};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against an in-flight instruction list model.
module tb_pipe_hazard_ctrl;
   localparam int REG_AW  = 4;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk;
   logic              resetn;
   logic              dec_valid;
   logic [REG_AW-1:0] dec_rs_a;
   logic [REG_AW-1:0] dec_rs_b;
   logic              dec_use_a;
   logic              dec_use_b;
   logic [REG_AW-1:0] dec_rd;
   logic              dec_wr_en;
   logic              dec_is_load;
   logic              ex_branch_taken;
   logic              pc_en;
   logic              fd_en;
   logic              fd_flush;
   logic              de_bubble;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic [2:0]        stage_valid;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .dec_valid(dec_valid),
      .dec_rs_a(dec_rs_a), .dec_rs_b(dec_rs_b), .dec_use_a(dec_use_a), .dec_use_b(dec_use_b),
      .dec_rd(dec_rd), .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load),
      .ex_branch_taken(ex_branch_taken), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
      .de_bubble(de_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stage_valid(stage_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit v;
      int rd;
      bit wr;
      bit ld;
      int ra;
      bit ua;
      int rb;
      bit ub;
   } ins_t;

   ins_t m_pipe[$];
   int   m_stall;
   int   m_flush;
   int   n_vec;
   int   n_err;
   bit   e_pc, e_fd, e_fl, e_bub, e_stall;
   int   e_fa, e_fb;

`ifdef PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   function automatic ins_t mk(bit v, int rd, bit wr, bit ld, int ra, bit ua, int rb, bit ub);
      ins_t t;
      t.v = v; t.rd = rd; t.wr = wr; t.ld = ld;
      t.ra = ra; t.ua = ua; t.rb = rb; t.ub = ub;
      return t;
   endfunction

   function automatic bit writes(ins_t e, bit u, int src);
      return u && e.v && e.wr && (e.rd == src) && (src != 15);
   endfunction

`ifdef PIPE_FWD_EN
   function automatic int fwd_src(int s, bit u);
      if (!m_pipe[0].v) return 0;
      if (writes(m_pipe[1], u, s) && !m_pipe[1].ld) return 1;
      if (writes(m_pipe[2], u, s)) return 2;
      return 0;
   endfunction
`endif

   task automatic model_reset();
      m_pipe.delete();
      repeat (3) m_pipe.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      m_stall = 0;
      m_flush = 0;
   endtask

   task automatic model_eval();
      ins_t d;
      bit   haz;
      d = mk(dec_valid, int'(dec_rd), dec_wr_en, dec_is_load,
             int'(dec_rs_a), dec_use_a, int'(dec_rs_b), dec_use_b);
      haz = 1'b0;
`ifdef PIPE_FWD_EN
      haz = m_pipe[0].ld && (writes(m_pipe[0], d.ua, d.ra) || writes(m_pipe[0], d.ub, d.rb));
      e_fa = fwd_src(m_pipe[0].ra, m_pipe[0].ua);
      e_fb = fwd_src(m_pipe[0].rb, m_pipe[0].ub);
`else
      for (int k = 0; k < 3; k++)
         if (writes(m_pipe[k], d.ua, d.ra) || writes(m_pipe[k], d.ub, d.rb)) haz = 1'b1;
      e_fa = 0;
      e_fb = 0;
`endif
      e_fl    = ex_branch_taken && m_pipe[0].v;
      e_stall = d.v && haz && !e_fl;
      e_pc    = !e_stall;
      e_fd    = !e_stall;
      e_bub   = e_fl || e_stall;
   endtask

   task automatic tick();
      ins_t nx;
      model_eval();
      @(posedge clk);
      if (e_fl) m_flush = (m_flush == CNT_MAX) ? CNT_MAX : m_flush + 1;
      else if (e_stall) m_stall = (m_stall == CNT_MAX) ? CNT_MAX : m_stall + 1;
      if (e_bub || !dec_valid) nx = mk(0, 0, 0, 0, 0, 0, 0, 0);
      else nx = mk(1, int'(dec_rd), dec_wr_en, dec_is_load, int'(dec_rs_a), dec_use_a,
                   int'(dec_rs_b), dec_use_b);
      m_pipe.push_front(nx);
      void'(m_pipe.pop_back());
      #1;
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic set_dec(bit v, int rd, bit wr, bit ld, int ra, bit ua, int rb, bit ub);
      dec_valid   = v;
      dec_rd      = REG_AW'(rd);
      dec_wr_en   = wr;
      dec_is_load = ld;
      dec_rs_a    = REG_AW'(ra);
      dec_use_a   = ua;
      dec_rs_b    = REG_AW'(rb);
      dec_use_b   = ub;
   endtask

   task automatic drain();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      ex_branch_taken = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      #1 resetn = 1'b0;
      model_reset();
      set_dec(1, 1, 1, 0, 1, 1, 1, 1);
      ex_branch_taken = 1'b1;
      #2;
      n_vec++;
      if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b1100) begin
         n_err++; $display("FAIL reset_ctl got=%b exp=1100", {pc_en, fd_en, fd_flush, de_bubble});
      end
      n_vec++;
      if ({fwd_a_sel, fwd_b_sel, stage_valid} !== 7'd0) begin
         n_err++; $display("FAIL reset_fwd_valid got=%b exp=0", {fwd_a_sel, fwd_b_sel, stage_valid});
      end
      n_vec++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         n_err++; $display("FAIL reset_cnt got stall=%0d flush=%0d exp 0", stall_cnt, flush_cnt);
      end
      ex_branch_taken = 1'b0;
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk) #1;
   endtask

   task automatic test_independent();
      drain();
      for (int i = 0; i < 8; i++) begin
         set_dec(1, 5 + i, 1, 0, 1 + (i % 4), 1, 1 + ((i + 1) % 4), 1);
         settle();
         n_vec++;
         if (pc_en !== 1'b1 || {fd_en, fd_flush, de_bubble} !== {e_fd, e_fl, e_bub}) begin
            n_err++; $display("FAIL indep_ctl i=%0d got=%b exp=1100", i, {pc_en, fd_en, fd_flush, de_bubble});
         end
         tick();
         if (i >= 2) begin
            n_vec++;
            if (stage_valid !== 3'b111) begin
               n_err++; $display("FAIL indep_valid i=%0d got=%b exp=111", i, stage_valid);
            end
         end
      end
      n_vec++;
      if (stall_cnt !== CNT_W'(0)) begin
         n_err++; $display("FAIL indep_stall_cnt got=%0d exp=0", stall_cnt);
      end
   endtask

   task automatic test_raw_stall();
      int nb;
      bit issued;
      int exp_nb;
      int s0;
      exp_nb = FWD ? 0 : 3;
      drain();
      s0 = m_stall;
      set_dec(1, 1, 1, 0, 2, 1, 3, 1);
      tick();
      set_dec(1, 2, 1, 0, 1, 1, 3, 1);
      nb = 0;
      issued = 1'b0;
      for (int c = 0; c < 8 && !issued; c++) begin
         settle();
         n_vec++;
         if ({pc_en, fd_en, fd_flush, de_bubble} !== {e_pc, e_fd, e_fl, e_bub}) begin
            n_err++; $display("FAIL raw_ctl c=%0d got=%b exp=%b", c,
                              {pc_en, fd_en, fd_flush, de_bubble}, {e_pc, e_fd, e_fl, e_bub});
         end
         if (de_bubble === 1'b1) nb++;
         else issued = 1'b1;
         tick();
      end
      n_vec++;
      if (!issued || nb != exp_nb) begin
         n_err++; $display("FAIL raw_stall_cycles got=%0d exp=%0d issued=%0d", nb, exp_nb, issued);
      end
      n_vec++;
      if (stall_cnt !== CNT_W'(s0 + exp_nb)) begin
         n_err++; $display("FAIL raw_stall_cnt got=%0d exp=%0d", stall_cnt, s0 + exp_nb);
      end
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      n_vec++;
      if (fwd_a_sel !== (FWD ? 2'd1 : 2'd0) || fwd_b_sel !== 2'd0) begin
         n_err++; $display("FAIL raw_fwd got a=%0d b=%0d exp a=%0d b=0", fwd_a_sel, fwd_b_sel, FWD ? 1 : 0);
      end
   endtask

   task automatic test_load_use();
      int nb;
      bit issued;
      int exp_nb;
      exp_nb = FWD ? 1 : 3;
      drain();
      set_dec(1, 5, 1, 1, 0, 0, 0, 0);
      tick();
      set_dec(1, 6, 1, 0, 5, 1, 5, 1);
      nb = 0;
      issued = 1'b0;
      for (int c = 0; c < 8 && !issued; c++) begin
         settle();
         n_vec++;
         if ({pc_en, fd_en, de_bubble} !== {e_pc, e_fd, e_bub}) begin
            n_err++; $display("FAIL ldu_ctl c=%0d got=%b exp=%b", c, {pc_en, fd_en, de_bubble}, {e_pc, e_fd, e_bub});
         end
         if (de_bubble === 1'b1) nb++;
         else issued = 1'b1;
         tick();
      end
      n_vec++;
      if (!issued || nb != exp_nb) begin
         n_err++; $display("FAIL ldu_stall_cycles got=%0d exp=%0d issued=%0d", nb, exp_nb, issued);
      end
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      n_vec++;
      if (fwd_a_sel !== (FWD ? 2'd2 : 2'd0) || fwd_b_sel !== (FWD ? 2'd2 : 2'd0)) begin
         n_err++; $display("FAIL ldu_fwd got a=%0d b=%0d exp=%0d", fwd_a_sel, fwd_b_sel, FWD ? 2 : 0);
      end
   endtask

   task automatic test_flush();
      int s0;
      drain();
      set_dec(1, 1, 1, 0, 2, 1, 3, 1);
      tick();
      set_dec(1, 14, 1, 0, 0, 0, 0, 0);
      tick();
      set_dec(1, 2, 1, 0, 1, 1, 14, 1);
      ex_branch_taken = 1'b1;
      settle();
      s0 = m_stall;
      n_vec++;
      if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b1111) begin
         n_err++; $display("FAIL flush_ctl got=%b exp=1111", {pc_en, fd_en, fd_flush, de_bubble});
      end
      tick();
      ex_branch_taken = 1'b0;
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      n_vec++;
      if (flush_cnt !== CNT_W'(1)) begin
         n_err++; $display("FAIL flush_cnt got=%0d exp=1", flush_cnt);
      end
      n_vec++;
      if (stall_cnt !== CNT_W'(s0)) begin
         n_err++; $display("FAIL flush_stall_cnt got=%0d exp=%0d", stall_cnt, s0);
      end
      n_vec++;
      if (stage_valid !== 3'b110) begin
         n_err++; $display("FAIL flush_bubble_valid got=%b exp=110", stage_valid);
      end
   endtask

   task automatic test_r15();
      drain();
      set_dec(1, 15, 1, 1, 0, 0, 0, 0);
      tick();
      set_dec(1, 3, 1, 0, 15, 1, 15, 1);
      for (int c = 0; c < 4; c++) begin
         settle();
         n_vec++;
         if (de_bubble !== 1'b0 || pc_en !== 1'b1) begin
            n_err++; $display("FAIL r15_nostall c=%0d got bubble=%b pc_en=%b exp 0/1", c, de_bubble, pc_en);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_stall();
      drain();
      set_dec(1, 7, 1, 1, 0, 0, 0, 0);
      tick();
      set_dec(1, 8, 1, 0, 7, 1, 0, 0);
      settle();
      if (!FWD) begin
         tick();
         settle();
      end
      n_vec++;
      if (de_bubble !== 1'b1) begin
         n_err++; $display("FAIL rst_pre_stall got bubble=%b exp=1", de_bubble);
      end
      resetn = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b1100) begin
         n_err++; $display("FAIL rst_mid_ctl got=%b exp=1100", {pc_en, fd_en, fd_flush, de_bubble});
      end
      n_vec++;
      if ({fwd_a_sel, fwd_b_sel, stage_valid} !== 7'd0 || stall_cnt !== '0 || flush_cnt !== '0) begin
         n_err++; $display("FAIL rst_mid_state got fwd/valid=%b stall=%0d flush=%0d exp all 0",
                           {fwd_a_sel, fwd_b_sel, stage_valid}, stall_cnt, flush_cnt);
      end
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk) #1;
   endtask

   task automatic test_saturation();
      int total;
      int stalls;
      int cyc;
      int limit;
      total  = (1 << CNT_W) + 5;
      stalls = 0;
      cyc    = 0;
      limit  = 8 * total;
      drain();
      if (FWD) set_dec(1, 1, 1, 1, 1, 1, 0, 0);
      else set_dec(1, 1, 1, 0, 1, 1, 0, 0);
      while (stalls < total && cyc < limit) begin
         settle();
         if (de_bubble === 1'b1) stalls++;
         tick();
         cyc++;
         n_vec++;
         if (stall_cnt !== CNT_W'(m_stall)) begin
            n_err++; $display("FAIL sat_track cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, m_stall);
         end
      end
      n_vec++;
      if (stalls < total) begin
         n_err++; $display("FAIL sat_timeout got=%0d stalls exp=%0d", stalls, total);
      end
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      n_vec++;
      if (stall_cnt !== CNT_W'(CNT_MAX)) begin
         n_err++; $display("FAIL sat_hold got=%0d exp=%0d", stall_cnt, CNT_MAX);
      end
   endtask

   task automatic test_random();
      bit hold;
      int r[4];
      hold = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!hold) begin
            for (int j = 0; j < 3; j++)
               r[j] = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
            set_dec($urandom_range(0, 7) != 0, r[0], $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    r[1], $urandom_range(0, 1) == 1, r[2], $urandom_range(0, 1) == 1);
         end
         ex_branch_taken = ($urandom_range(0, 9) == 0);
         settle();
         n_vec++;
         if ({pc_en, fd_en, fd_flush, de_bubble} !== {e_pc, e_fd, e_fl, e_bub} ||
             fwd_a_sel !== 2'(e_fa) || fwd_b_sel !== 2'(e_fb)) begin
            n_err++; $display("FAIL rand_comb c=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", c,
                              {pc_en, fd_en, fd_flush, de_bubble}, fwd_a_sel, fwd_b_sel,
                              {e_pc, e_fd, e_fl, e_bub}, e_fa, e_fb);
         end
         hold = e_stall;
         tick();
         n_vec++;
         if (stage_valid !== {m_pipe[2].v, m_pipe[1].v, m_pipe[0].v} ||
             stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
            n_err++; $display("FAIL rand_state c=%0d got v=%b s=%0d f=%0d exp v=%b s=%0d f=%0d", c,
                              stage_valid, stall_cnt, flush_cnt,
                              {m_pipe[2].v, m_pipe[1].v, m_pipe[0].v}, m_stall, m_flush);
         end
      end
      ex_branch_taken = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired vectors=%0d miscompares=%0d", n_vec, n_err);
      $fatal(1);
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      ex_branch_taken = 1'b0;
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      test_reset();
      test_independent();
      test_raw_stall();
      test_load_use();
      test_flush();
      test_r15();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage ARM pipeline (FTCH, DECD, EXEC, MEMW, WRBK). It tracks the register-write state of every in-flight instruction and compares it with the source registers of the instruction in DECD. From that it stalls FTCH/DECD, inserts bubbles into EXEC, and flushes wrong-path instructions when a branch is taken in EXEC. It sits beside the stage registers and drives their enables; optionally it also drives EXEC operand-forwarding selects.

## Interface
Parameters:
- REG_AW, 4, register address width
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- dec_valid  in  1  DECD holds a real instruction
- dec_rs_a, dec_rs_b  in  REG_AW  DECD source registers
- dec_use_a, dec_use_b  in  1  source actually read
- dec_rd  in  REG_AW  DECD destination register
- dec_wr_en  in  1  DECD instruction writes dec_rd
- dec_is_load  in  1  DECD instruction is LDR
- ex_branch_taken  in  1  EXEC holds a branch (BL) whose condition passed
- pc_en  out  1  PC register update enable
- fd_en  out  1  FTCH→DECD latch enable
- fd_flush  out  1  kill FTCH and DECD contents
- de_bubble  out  1  load NOP into EXEC instead of DECD instruction
- fwd_a_sel, fwd_b_sel  out  2  EXEC operand source: 0 regfile, 1 MEMW result, 2 WRBK result
- stage_valid  out  3  valid bits {WRBK, MEMW, EXEC}
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Internal tracking shift register for EXEC, MEMW, WRBK. Each entry holds valid, rd, wr_en, is_load, rs_a/rs_b and use bits.
- Each clk: WRBK←MEMW, MEMW←EXEC. EXEC←DECD fields, or a zeroed entry when de_bubble or fd_flush.
- A source matches a stage when use=1, the stage is valid with wr_en=1, and rd equals the source. Register 15 never matches.
- Hazard, PIPE_FWD_EN undefined: a DECD source matches EXEC, MEMW or WRBK. The register file has no write-through, so WRBK counts.
- Hazard, PIPE_FWD_EN defined: a DECD source matches EXEC and the EXEC entry has is_load=1 (load-use).
- Priority 1, flush: ex_branch_taken && EXEC valid. Outputs fd_flush=1, pc_en=1, fd_en=1, de_bubble=1. flush_cnt increments. The hazard is ignored.
- Priority 2, stall: dec_valid && hazard. Outputs pc_en=0, fd_en=0, de_bubble=1, fd_flush=0. stall_cnt increments.
- Otherwise: pc_en=1, fd_en=1, de_bubble=0, fd_flush=0.
- Counters saturate at all-ones and do not wrap.

## Timing
- pc_en, fd_en, fd_flush, de_bubble and fwd_*_sel are combinational from the inputs and the tracking state, in the same cycle; the tracking state, stage_valid and the counters update only on clk, one cycle after a condition is seen.
- Non-forwarding dependent pair: the consumer is held in DECD for 3 cycles after an adjacent producer, then issues.
- Forwarding: adjacent ALU→ALU pair has 0 stall cycles; LDR→use has exactly 1.
- Flush: the instruction after the branch is bubbled into EXEC on the same edge. Wrong-path FTCH/DECD are discarded. The new-target fetch reaches DECD 2 cycles later.
- A taken branch coinciding with a stall: the flush wins and the stall is not counted.
- Reset (asynchronous, any cycle, including mid-stall): all tracking entries become invalid and counters clear. Outputs immediately become pc_en=1, fd_en=1, fd_flush=0, de_bubble=0, fwd_*_sel=0, stage_valid=0.

## Configuration
- PIPE_FWD_EN defined:
  - Load-use-only hazard rule.
  - fwd_a_sel/fwd_b_sel are computed per EXEC source: 1 if MEMW matches, else 2 if WRBK matches, else 0. The younger instruction (MEMW) wins.
  - A MEMW-stage load never matches, because the load-use stall guarantees the load has reached WRBK.
- PIPE_FWD_EN undefined: full RAW stall rule, and fwd_*_sel are tied to 0.

## Test plan
- Reset, then a stream of independent ADDs (r1..r4 into distinct rd) → pc_en=1 every cycle, stall_cnt=0, stage_valid=3'b111 after 3 cycles.
- ADD r1 then SUB r2,r1,r3; no FWD → de_bubble high 3 consecutive cycles, stall_cnt=3. With FWD → 0 stalls and fwd_a_sel=1 when SUB is in EXEC.
- With FWD: LDR r5 then ADD r6,r5,r5 → exactly 1 stall cycle, then fwd_a_sel=fwd_b_sel=2.
- BL taken in EXEC while DECD holds a dependent of an in-flight write → fd_flush=1, pc_en=1, stall not counted, flush_cnt=1.
- Source r15 equal to a pending rd=15 → no stall.
- Assert resetn low during the 2nd stall cycle → outputs return to reset values immediately and stall_cnt=0. Drive 2^CNT_W+5 stalls → stall_cnt holds at all-ones.
